// File: rtl/onedconv_row_feeder.sv
// Row feeder for the 1-D convolution engine: walks a Width x Height frame in raster order,
// issuing memory reads and one Start pulse per row, with a drain gap between rows.
module onedconv_row_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIM_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ROW_GAP    = 4
) (
    input  logic                  ONEDCONV_ROW_FEEDER_Clk,
    input  logic                  ONEDCONV_ROW_FEEDER_Reset,
    input  logic                  ONEDCONV_ROW_FEEDER_Go,
    input  logic [DIM_WIDTH-1:0]  ONEDCONV_ROW_FEEDER_Width,
    input  logic [DIM_WIDTH-1:0]  ONEDCONV_ROW_FEEDER_Height,
    input  logic [DATA_WIDTH-1:0] ONEDCONV_ROW_FEEDER_Rd_Data,
    output logic                  ONEDCONV_ROW_FEEDER_Rd_En,
    output logic [ADDR_WIDTH-1:0] ONEDCONV_ROW_FEEDER_Rd_Addr,
    output logic                  ONEDCONV_ROW_FEEDER_Start,
    output logic [DATA_WIDTH-1:0] ONEDCONV_ROW_FEEDER_Pixel,
    output logic                  ONEDCONV_ROW_FEEDER_Pixel_Valid,
    output logic                  ONEDCONV_ROW_FEEDER_Row_Done,
    output logic                  ONEDCONV_ROW_FEEDER_Frame_Done,
    output logic                  ONEDCONV_ROW_FEEDER_Busy
);

    localparam int unsigned GapW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StStream, StGap, StDone} state_e;

    state_e                state_q, state_d;
    logic [DIM_WIDTH-1:0]  width_q, height_q;
    logic [DIM_WIDTH-1:0]  col_q, row_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [GapW-1:0]       gap_q;
    logic                  pv_q;

    logic go_ok, col_last, row_last, gap_last, rd_en;

    assign go_ok    = ONEDCONV_ROW_FEEDER_Go && (ONEDCONV_ROW_FEEDER_Width != '0)
                      && (ONEDCONV_ROW_FEEDER_Height != '0);
    assign col_last = (col_q == width_q - DIM_WIDTH'(1));
    assign row_last = (row_q == height_q - DIM_WIDTH'(1));
    assign gap_last = (gap_q == GapW'(ROW_GAP - 1));

    always_ff @(posedge ONEDCONV_ROW_FEEDER_Clk) begin
        if (ONEDCONV_ROW_FEEDER_Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (go_ok) state_d = StStart;
            StStart:  state_d = StStream;
            StStream: if (col_last) state_d = row_last ? StDone : StGap;
            StGap:    if (gap_last) state_d = StStart;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_en                          = (state_q == StStream);
        ONEDCONV_ROW_FEEDER_Rd_En      = rd_en;
        ONEDCONV_ROW_FEEDER_Rd_Addr    = rd_en ? addr_q : '0;
        ONEDCONV_ROW_FEEDER_Start      = (state_q == StStart);
        ONEDCONV_ROW_FEEDER_Row_Done   = ((state_q == StGap) && (gap_q == '0))
                                         || (state_q == StDone);
        ONEDCONV_ROW_FEEDER_Frame_Done = (state_q == StDone);
        ONEDCONV_ROW_FEEDER_Busy       = (state_q != StIdle);
    end

    assign ONEDCONV_ROW_FEEDER_Pixel       = ONEDCONV_ROW_FEEDER_Rd_Data;
    assign ONEDCONV_ROW_FEEDER_Pixel_Valid = pv_q;

    // Address keeps running across the gap so it always equals row*Width+column.
    always_ff @(posedge ONEDCONV_ROW_FEEDER_Clk) begin
        if (ONEDCONV_ROW_FEEDER_Reset) begin
            width_q  <= '0;
            height_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            gap_q    <= '0;
            pv_q     <= 1'b0;
        end else begin
            pv_q <= rd_en;
            unique case (state_q)
                StIdle: begin
                    if (go_ok) begin
                        width_q  <= ONEDCONV_ROW_FEEDER_Width;
                        height_q <= ONEDCONV_ROW_FEEDER_Height;
                        col_q    <= '0;
                        row_q    <= '0;
                        addr_q   <= '0;
                        gap_q    <= '0;
                    end
                end
                StStream: begin
                    col_q  <= col_q + DIM_WIDTH'(1);
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    gap_q  <= '0;
                end
                StGap: begin
                    if (gap_last) begin
                        gap_q <= '0;
                        col_q <= '0;
                        row_q <= row_q + DIM_WIDTH'(1);
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
